// File: rtl/port_monitor_hub_pkg.sv
// Shared constants and helpers for the port monitor hub: data/address width,
// rate control width, and configuration-check helpers.
package port_monitor_hub_pkg;

    localparam int WORD_SIZE = 16;
    localparam int RATE_BITS = 3;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // True when addr has all bits below log2(n) clear.
    function automatic bit is_aligned(input logic [WORD_SIZE-1:0] addr, input int n);
        return (addr & WORD_SIZE'(n - 1)) == {WORD_SIZE{1'b0}};
    endfunction

endpackage

// File: rtl/port_monitor_hub_ce_tick_gen.sv
// Clock-enable generator: free-running tick accumulator or synchronised,
// edge-detected single-step button, producing a one-cycle cpu_ce pulse.
module ce_tick_gen
    import port_monitor_hub_pkg::*;
#(
    parameter int SLOWDOWN = 20
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [RATE_BITS-1:0] rate,
    input  logic                 run,
    input  logic                 step_btn,
    output logic                 cpu_ce
);

    localparam int ACC_W = SLOWDOWN + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             btn_prev_q, btn_prev_d;
    logic             cpu_ce_q, cpu_ce_d;

    logic [ACC_W:0]   inc_s;
    logic [ACC_W:0]   sum_s;
    logic             tick_s;
    logic             step_edge_s;

    // Next-state logic: accumulator carry, button synchroniser and cpu_ce source select.
    always_comb begin
        inc_s       = {{ACC_W{1'b0}}, 1'b1} << {rate, 1'b0};
        sum_s       = {1'b0, acc_q} + inc_s;
        acc_d       = sum_s[ACC_W-1:0];
        tick_s      = sum_s[ACC_W];
        sync1_d     = step_btn;
        sync2_d     = sync1_q;
        btn_prev_d  = sync2_q;
        step_edge_s = sync2_q & ~btn_prev_q;
        // The synchroniser keeps running in both modes so switching to step
        // mode with the button already held does not fire a spurious pulse.
        if (run) begin
            cpu_ce_d = tick_s;
        end else begin
            cpu_ce_d = step_edge_s;
        end
    end

    // State registers for the accumulator, synchroniser chain and cpu_ce pulse.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= {ACC_W{1'b0}};
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_prev_q <= 1'b0;
            cpu_ce_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_prev_q <= btn_prev_d;
            cpu_ce_q   <= cpu_ce_d;
        end
    end

    assign cpu_ce = cpu_ce_q;

endmodule

// File: rtl/port_monitor_hub.sv
// Board-side CPU I/O block: port write latches with dirty flags, registered
// port reads, and a selectable/freezable channel for the seven-segment driver.
module port_monitor_hub
    import port_monitor_hub_pkg::*;
#(
    parameter int                   NUM_CHANNELS = 4,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR    = {WORD_SIZE{1'b0}},
    parameter int                   SLOWDOWN     = 20,
    parameter int                   CH_BITS      = $clog2(NUM_CHANNELS)
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic [RATE_BITS-1:0] rate,
    input  logic                 run,
    input  logic                 step_btn,
    output logic                 cpu_ce,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portset,
    input  logic                 portget,
    output logic [WORD_SIZE-1:0] portrdata,
    input  logic [CH_BITS-1:0]   show_sel,
    input  logic                 hold,
    output logic [WORD_SIZE-1:0] show_val,
    output logic                 show_dirty
);

    generate
        if (!is_pow2(NUM_CHANNELS) || (NUM_CHANNELS < 2)) begin : g_bad_num_channels
            $error("port_monitor_hub: NUM_CHANNELS must be a power of two >= 2");
        end
        if (CH_BITS != $clog2(NUM_CHANNELS)) begin : g_bad_ch_bits
            $error("port_monitor_hub: CH_BITS must equal clog2(NUM_CHANNELS)");
        end
        if (!is_aligned(BASE_ADDR, NUM_CHANNELS)) begin : g_bad_base
            $error("port_monitor_hub: BASE_ADDR must be aligned to NUM_CHANNELS");
        end
    endgenerate

    logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] chan_q, chan_d;
    logic [NUM_CHANNELS-1:0]                dirty_q, dirty_d;
    logic [WORD_SIZE-1:0]                   portrdata_q, portrdata_d;
    logic [WORD_SIZE-1:0]                   show_val_q, show_val_d;
    logic                                   show_dirty_q, show_dirty_d;

    logic                                   cpu_ce_s;
    logic                                   hit_s;
    logic [CH_BITS-1:0]                     idx_s;
    logic                                   wr_s;
    logic                                   rd_s;

    ce_tick_gen #(
        .SLOWDOWN (SLOWDOWN)
    ) u_ce_tick_gen (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .rate     (rate),
        .run      (run),
        .step_btn (step_btn),
        .cpu_ce   (cpu_ce_s)
    );

    // Port decode: upper address bits select the block, low bits the channel.
    always_comb begin
        hit_s = (portaddr[WORD_SIZE-1:CH_BITS] == BASE_ADDR[WORD_SIZE-1:CH_BITS]);
        idx_s = portaddr[CH_BITS-1:0];
        wr_s  = cpu_ce_s & portset & hit_s;
        rd_s  = cpu_ce_s & portget;
    end

    // Channel latches and read path; reads sample the pre-write latch contents.
    always_comb begin
        chan_d = chan_q;
        if (wr_s) begin
            chan_d[idx_s] = portval;
        end else begin
            chan_d = chan_q;
        end

        portrdata_d = portrdata_q;
        if (rd_s) begin
            if (hit_s) begin
                portrdata_d = chan_q[idx_s];
            end else begin
                portrdata_d = {WORD_SIZE{1'b0}};
            end
        end else begin
            portrdata_d = portrdata_q;
        end
    end

    // Display mux and dirty flags; a write in the same cycle outranks the display clear.
    always_comb begin
        dirty_d      = dirty_q;
        show_val_d   = show_val_q;
        show_dirty_d = show_dirty_q;
        if (!hold) begin
            show_val_d        = chan_q[show_sel];
            show_dirty_d      = dirty_q[show_sel];
            dirty_d[show_sel] = 1'b0;
        end else begin
            show_val_d   = show_val_q;
            show_dirty_d = show_dirty_q;
        end
        if (wr_s) begin
            dirty_d[idx_s] = 1'b1;
        end else begin
            dirty_d[idx_s] = dirty_d[idx_s];
        end
    end

    // Channel, dirty, read-data and display registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q       <= '0;
            dirty_q      <= {NUM_CHANNELS{1'b0}};
            portrdata_q  <= {WORD_SIZE{1'b0}};
            show_val_q   <= {WORD_SIZE{1'b0}};
            show_dirty_q <= 1'b0;
        end else begin
            chan_q       <= chan_d;
            dirty_q      <= dirty_d;
            portrdata_q  <= portrdata_d;
            show_val_q   <= show_val_d;
            show_dirty_q <= show_dirty_d;
        end
    end

    assign cpu_ce     = cpu_ce_s;
    assign portrdata  = portrdata_q;
    assign show_val   = show_val_q;
    assign show_dirty = show_dirty_q;

endmodule

// File: tb/tb_port_monitor_hub.sv
// Directed bench for port_monitor_hub: tick timing, single-step, port
// write/read ordering, display dirty/hold behaviour and asynchronous reset.
module tb_port_monitor_hub;

    localparam logic [15:0] BASE = 16'h0040;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic [2:0]  rate;
    logic        run;
    logic        step_btn;
    logic        cpu_ce;
    logic [15:0] portaddr;
    logic [15:0] portval;
    logic        portset;
    logic        portget;
    logic [15:0] portrdata;
    logic [1:0]  show_sel;
    logic        hold;
    logic [15:0] show_val;
    logic        show_dirty;

    int n_cmp = 0;
    int n_bad = 0;

    port_monitor_hub #(
        .NUM_CHANNELS (4),
        .BASE_ADDR    (BASE),
        .SLOWDOWN     (4)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .rate       (rate),
        .run        (run),
        .step_btn   (step_btn),
        .cpu_ce     (cpu_ce),
        .portaddr   (portaddr),
        .portval    (portval),
        .portset    (portset),
        .portget    (portget),
        .portrdata  (portrdata),
        .show_sel   (show_sel),
        .hold       (hold),
        .show_val   (show_val),
        .show_dirty (show_dirty)
    );

    always #5 mclk = ~mclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Negedges until cpu_ce is seen high, or -1 if the budget runs out.
    task automatic count_to_ce(input int budget, output int cycles);
        int  c;
        bit  found;
        c = 0;
        found = 1'b0;
        while (!found && c < budget) begin
            @(negedge mclk);
            c++;
            if (cpu_ce === 1'b1) found = 1'b1;
        end
        cycles = found ? c : -1;
    endtask

    // One CPU port cycle via a single-step press (run must be 0).
    task automatic cpu_op(input logic [15:0] addr, input logic [15:0] val,
                          input logic set, input logic get);
        int c;
        @(negedge mclk);
        step_btn = 1'b0; portset = 1'b0; portget = 1'b0;
        repeat (4) @(negedge mclk);
        portaddr = addr; portval = val; portset = set; portget = get;
        step_btn = 1'b1;
        count_to_ce(10, c);
        if (c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_op_ce_timeout: addr=%h no cpu_ce within 10 cycles", addr);
        end
        @(negedge mclk);
        portset = 1'b0; portget = 1'b0; step_btn = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        rst_n = 1'b0; run = 1'b1; rate = 3'd0; step_btn = 1'b0;
        portaddr = 16'h0000; portval = 16'h0000; portset = 1'b0; portget = 1'b0;
        show_sel = 2'd0; hold = 1'b0;
        #3;
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_ce: got %b want 0", cpu_ce); end
        n_cmp++; if (portrdata !== 16'h0000) begin n_bad++; $display("FAIL reset_portrdata: got %h want 0000", portrdata); end
        n_cmp++; if (show_val !== 16'h0000) begin n_bad++; $display("FAIL reset_show_val: got %h want 0000", show_val); end
        n_cmp++; if (show_dirty !== 1'b0) begin n_bad++; $display("FAIL reset_show_dirty: got %b want 0", show_dirty); end
        @(negedge mclk);
        rst_n = 1'b1;
        count_to_ce(100, c);
        n_cmp++; if (c !== 32) begin n_bad++; $display("FAIL reset_first_tick: got %0d cycles want 32", c); end
    endtask

    task automatic test_tick_rate();
        int c;
        count_to_ce(100, c);
        n_cmp++; if (c !== 32) begin n_bad++; $display("FAIL tick_rate0_period: got %0d want 32", c); end
        @(negedge mclk);
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL tick_pulse_width: got %b want 0", cpu_ce); end
        rate = 3'd1;
        count_to_ce(100, c);
        count_to_ce(20, c);
        n_cmp++; if (c !== 8) begin n_bad++; $display("FAIL tick_rate1_period_a: got %0d want 8", c); end
        count_to_ce(20, c);
        n_cmp++; if (c !== 8) begin n_bad++; $display("FAIL tick_rate1_period_b: got %0d want 8", c); end
    endtask

    task automatic test_step();
        int c;
        int pulses;
        @(negedge mclk);
        run = 1'b0;
        repeat (4) @(negedge mclk);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge mclk);
            if (cpu_ce === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL step_ticks_suppressed: got %0d pulses want 0", pulses); end
        step_btn = 1'b1;
        count_to_ce(10, c);
        n_cmp++; if (c < 3 || c > 4) begin n_bad++; $display("FAIL step_latency: got %0d cycles want 3..4", c); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk);
            if (cpu_ce === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL step_held_repeat: got %0d pulses want 0", pulses); end
        step_btn = 1'b0;
    endtask

    task automatic test_write_display();
        show_sel = 2'd2;
        cpu_op(BASE + 16'd2, 16'hBEEF, 1'b1, 1'b0);
        @(negedge mclk);
        n_cmp++; if (show_val !== 16'hBEEF) begin n_bad++; $display("FAIL wr_show_val: got %h want beef", show_val); end
        n_cmp++; if (show_dirty !== 1'b1) begin n_bad++; $display("FAIL wr_show_dirty_set: got %b want 1", show_dirty); end
        @(negedge mclk);
        n_cmp++; if (show_dirty !== 1'b0) begin n_bad++; $display("FAIL wr_show_dirty_clear: got %b want 0", show_dirty); end
    endtask

    task automatic test_read_before_write();
        cpu_op(BASE + 16'd1, 16'h1234, 1'b1, 1'b0);
        cpu_op(BASE + 16'd1, 16'h5678, 1'b1, 1'b1);
        n_cmp++; if (portrdata !== 16'h1234) begin n_bad++; $display("FAIL rbw_old_value: got %h want 1234", portrdata); end
        cpu_op(BASE + 16'd1, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if (portrdata !== 16'h5678) begin n_bad++; $display("FAIL rbw_new_value: got %h want 5678", portrdata); end
        cpu_op(16'h0051, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if (portrdata !== 16'h0000) begin n_bad++; $display("FAIL read_miss: got %h want 0000", portrdata); end
        cpu_op(16'h0052, 16'hDEAD, 1'b1, 1'b0);
        cpu_op(BASE + 16'd2, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if (portrdata !== 16'hBEEF) begin n_bad++; $display("FAIL write_miss_ignored: got %h want beef", portrdata); end
        repeat (5) @(negedge mclk);
        n_cmp++; if (portrdata !== 16'hBEEF) begin n_bad++; $display("FAIL rdata_holds: got %h want beef", portrdata); end
    endtask

    task automatic test_hold();
        @(negedge mclk);
        show_sel = 2'd1; hold = 1'b0;
        repeat (3) @(negedge mclk);
        hold = 1'b1;
        cpu_op(BASE + 16'd1, 16'h00AA, 1'b1, 1'b0);
        @(negedge mclk);
        n_cmp++; if (show_val !== 16'h5678) begin n_bad++; $display("FAIL hold_val_frozen: got %h want 5678", show_val); end
        n_cmp++; if (show_dirty !== 1'b0) begin n_bad++; $display("FAIL hold_dirty_frozen: got %b want 0", show_dirty); end
        hold = 1'b0;
        @(negedge mclk);
        n_cmp++; if (show_val !== 16'h00AA) begin n_bad++; $display("FAIL unhold_val: got %h want 00aa", show_val); end
        n_cmp++; if (show_dirty !== 1'b1) begin n_bad++; $display("FAIL unhold_dirty: got %b want 1", show_dirty); end
    endtask

    task automatic test_no_ce_and_reset();
        int c;
        @(negedge mclk);
        show_sel = 2'd3;
        repeat (3) @(negedge mclk);
        portaddr = BASE + 16'd3; portval = 16'hFFFF; portset = 1'b1; portget = 1'b1;
        repeat (10) @(negedge mclk);
        portset = 1'b0; portget = 1'b0;
        @(negedge mclk);
        n_cmp++; if (show_val !== 16'h0000) begin n_bad++; $display("FAIL no_ce_write: got %h want 0000", show_val); end
        n_cmp++; if (show_dirty !== 1'b0) begin n_bad++; $display("FAIL no_ce_dirty: got %b want 0", show_dirty); end
        n_cmp++; if (portrdata !== 16'hBEEF) begin n_bad++; $display("FAIL no_ce_read: got %h want beef", portrdata); end
        show_sel = 2'd2; run = 1'b1; rate = 3'd0;
        repeat (20) @(negedge mclk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (cpu_ce !== 1'b0) begin n_bad++; $display("FAIL midrst_cpu_ce: got %b want 0", cpu_ce); end
        n_cmp++; if (portrdata !== 16'h0000) begin n_bad++; $display("FAIL midrst_portrdata: got %h want 0000", portrdata); end
        n_cmp++; if (show_val !== 16'h0000) begin n_bad++; $display("FAIL midrst_show_val: got %h want 0000", show_val); end
        n_cmp++; if (show_dirty !== 1'b0) begin n_bad++; $display("FAIL midrst_show_dirty: got %b want 0", show_dirty); end
        @(negedge mclk);
        rate = 3'd1;
        rst_n = 1'b1;
        count_to_ce(50, c);
        n_cmp++; if (c !== 8) begin n_bad++; $display("FAIL midrst_first_tick: got %0d want 8", c); end
        n_cmp++; if (show_val !== 16'h0000) begin n_bad++; $display("FAIL midrst_chan_cleared: got %h want 0000", show_val); end
    endtask

    initial begin
        test_reset();
        test_tick_rate();
        test_step();
        test_write_display();
        test_read_before_write();
        test_hold();
        test_no_ce_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
